// File: rtl/ps2_cmd_sequencer.sv
// Host-side command sequencer for a PS/2 keyboard: sends command/argument bytes, handles
// ACK/RESEND/timeouts, optionally runs the power-on reset/BAT handshake, forwards unconsumed rx bytes.
module ps2_cmd_sequencer #(
    parameter bit          AUTO_INIT      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd2500000,
    parameter int unsigned BAT_CYCLES     = 32'd75000000,
    parameter int unsigned MAX_RETRY      = 32'd3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [7:0] cmdByte,
    input  logic       cmdHasArg,
    input  logic [7:0] cmdArg,
    output logic       doneValid,
    output logic [1:0] doneErr,
    output logic       initDone,
    output logic       busy,
    output logic [7:0] txData,
    output logic       txValid,
    input  logic       txReady,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    output logic [7:0] scanData,
    output logic       scanValid
);

    localparam logic [31:0] ACK_LAST      = 32'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [31:0] BAT_LAST      = 32'(BAT_CYCLES - 32'd1);
    localparam logic [7:0]  RETRY_MAX     = 8'(MAX_RETRY);
    localparam logic [7:0]  BYTE_ACK      = 8'hFA;
    localparam logic [7:0]  BYTE_RESEND   = 8'hFE;
    localparam logic [7:0]  BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0]  BYTE_BAT_FAIL = 8'hFC;
    localparam logic [7:0]  BYTE_RESET    = 8'hFF;
    localparam logic [1:0]  ERR_OK        = 2'd0;
    localparam logic [1:0]  ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0]  ERR_RESEND    = 2'd2;
    localparam logic [1:0]  ERR_BAT       = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_ACK  = 3'd2,
        ST_BAT  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  cur_byte_r, cur_byte_s;
    logic [7:0]  arg_byte_r, arg_byte_s;
    logic        has_arg_r, has_arg_s;
    logic        phase_r, phase_s;
    logic        is_init_r, is_init_s;
    logic [7:0]  retry_r, retry_s;
    logic [31:0] timer_r, timer_s;
    logic [1:0]  err_r, err_s;
    logic        init_pending_r, init_pending_s;
    logic        init_done_r, init_done_s;
    logic [7:0]  scan_data_r, scan_data_s;
    logic        scan_valid_r;
    logic        forward_s;

    // State and datapath registers; reset aborts everything and re-arms auto-init
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= ST_IDLE;
            cur_byte_r     <= 8'h00;
            arg_byte_r     <= 8'h00;
            has_arg_r      <= 1'b0;
            phase_r        <= 1'b0;
            is_init_r      <= 1'b0;
            retry_r        <= 8'd0;
            timer_r        <= 32'd0;
            err_r          <= 2'd0;
            init_pending_r <= AUTO_INIT;
            init_done_r    <= ~AUTO_INIT;
            scan_data_r    <= 8'h00;
            scan_valid_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            cur_byte_r     <= cur_byte_s;
            arg_byte_r     <= arg_byte_s;
            has_arg_r      <= has_arg_s;
            phase_r        <= phase_s;
            is_init_r      <= is_init_s;
            retry_r        <= retry_s;
            timer_r        <= timer_s;
            err_r          <= err_s;
            init_pending_r <= init_pending_s;
            init_done_r    <= init_done_s;
            scan_data_r    <= scan_data_s;
            scan_valid_r   <= forward_s;
        end
    end

    // Next-state logic; an rx byte arriving on the timeout cycle always takes priority
    always_comb begin
        state_s        = state_r;
        cur_byte_s     = cur_byte_r;
        arg_byte_s     = arg_byte_r;
        has_arg_s      = has_arg_r;
        phase_s        = phase_r;
        is_init_s      = is_init_r;
        retry_s        = retry_r;
        timer_s        = timer_r;
        err_s          = err_r;
        init_pending_s = init_pending_r;
        init_done_s    = init_done_r;
        forward_s      = rxValid;
        case (state_r)
            ST_IDLE: begin
                if (init_pending_r) begin
                    cur_byte_s = BYTE_RESET;
                    has_arg_s  = 1'b0;
                    phase_s    = 1'b0;
                    retry_s    = 8'd0;
                    is_init_s  = 1'b1;
                    state_s    = ST_TX;
                end else if (cmdValid) begin
                    cur_byte_s = cmdByte;
                    arg_byte_s = cmdArg;
                    has_arg_s  = cmdHasArg;
                    phase_s    = 1'b0;
                    retry_s    = 8'd0;
                    is_init_s  = 1'b0;
                    state_s    = ST_TX;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TX: begin
                if (txReady) begin
                    timer_s = 32'd0;
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_ACK: begin
                timer_s = timer_r + 32'd1;
                if (rxValid && (rxData == BYTE_ACK)) begin
                    forward_s = 1'b0;
                    if (!phase_r && has_arg_r) begin
                        phase_s    = 1'b1;
                        cur_byte_s = arg_byte_r;
                        retry_s    = 8'd0;
                        state_s    = ST_TX;
                    end else if (is_init_r) begin
                        timer_s = 32'd0;
                        state_s = ST_BAT;
                    end else begin
                        err_s   = ERR_OK;
                        state_s = ST_FIN;
                    end
                end else if (rxValid && (rxData == BYTE_RESEND)) begin
                    forward_s = 1'b0;
                    if (retry_r == RETRY_MAX) begin
                        err_s   = ERR_RESEND;
                        state_s = ST_FIN;
                    end else begin
                        retry_s = retry_r + 8'd1;
                        state_s = ST_TX;
                    end
                end else if (!rxValid && (timer_r >= ACK_LAST)) begin
                    err_s   = ERR_TIMEOUT;
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_ACK;
                end
            end
            ST_BAT: begin
                timer_s = timer_r + 32'd1;
                if (rxValid && (rxData == BYTE_BAT_OK)) begin
                    forward_s = 1'b0;
                    err_s     = ERR_OK;
                    state_s   = ST_FIN;
                end else if (rxValid && (rxData == BYTE_BAT_FAIL)) begin
                    forward_s = 1'b0;
                    err_s     = ERR_BAT;
                    state_s   = ST_FIN;
                end else if (!rxValid && (timer_r >= BAT_LAST)) begin
                    err_s   = ERR_TIMEOUT;
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_BAT;
                end
            end
            ST_FIN: begin
                if (is_init_r) begin
                    init_done_s    = 1'b1;
                    init_pending_s = 1'b0;
                end else begin
                    init_done_s = init_done_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        scan_data_s = forward_s ? rxData : scan_data_r;
    end

    assign cmdReady  = (state_r == ST_IDLE) && !init_pending_r;
    assign busy      = (state_r != ST_IDLE) || init_pending_r;
    assign txValid   = (state_r == ST_TX);
    assign txData    = cur_byte_r;
    assign doneValid = (state_r == ST_FIN);
    assign doneErr   = err_r;
    assign initDone  = init_done_r;
    assign scanData  = scan_data_r;
    assign scanValid = scan_valid_r;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: table of scripted commands, hand-written corner
// sequences, and randomized commands checked against a transaction-level keyboard model.
module tb_ps2_cmd_sequencer;

    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [7:0] cmdByte = 8'h00;
    logic       cmdHasArg = 1'b0;
    logic [7:0] cmdArg = 8'h00;
    logic       doneValid;
    logic [1:0] doneErr;
    logic       initDone;
    logic       busy;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       rxValid = 1'b0;
    logic [7:0] scanData;
    logic       scanValid;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] scan_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic        has_arg;
        logic [7:0]  arg;
        logic [15:0] script;
        logic [1:0]  err;
        int          ntx;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(
        .AUTO_INIT(1'b1), .TIMEOUT_CYCLES(64), .BAT_CYCLES(256), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rstn(rstn), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdByte(cmdByte),
        .cmdHasArg(cmdHasArg), .cmdArg(cmdArg), .doneValid(doneValid), .doneErr(doneErr),
        .initDone(initDone), .busy(busy), .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .scanData(scanData), .scanValid(scanValid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every forwarded byte must match the next expected one, in order
    always @(negedge clk) begin
        if (rstn && scanValid) begin
            if (scan_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scan_unexpected: got 0x%0h, expected no scan byte", scanData);
            end else begin
                chk("scan_byte", {24'd0, scanData}, {24'd0, scan_q.pop_front()});
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        tick();
        rxValid = 1'b0;
        rxData  = 8'($urandom);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!txValid && n < 50) begin
            tick();
            n++;
        end
        chk("tx_valid_seen", {31'd0, txValid}, 32'd1);
    endtask

    task automatic handshake(input int d);
        repeat (d) tick();
        txReady = 1'b1;
        tick();
        txReady = 1'b0;
        chk("tx_drop", {31'd0, txValid}, 32'd0);
    endtask

    task automatic accept(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg);
        int n = 0;
        while (!cmdReady && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready", {31'd0, cmdReady}, 32'd1);
        cmdValid  = 1'b1;
        cmdByte   = cmd;
        cmdHasArg = has_arg;
        cmdArg    = arg;
        tick();
        cmdValid  = 1'b0;
        cmdByte   = 8'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("ready_low_busy", {31'd0, cmdReady}, 32'd0);
    endtask

    task automatic finish_done(input logic [1:0] exp_err);
        int n = 0;
        while (!doneValid && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, doneValid}, 32'd1);
        chk("done_err", {30'd0, doneErr}, {30'd0, exp_err});
        tick();
        chk("done_pulse", {31'd0, doneValid}, 32'd0);
        chk("ready_after_fin", {31'd0, cmdReady}, 32'd1);
    endtask

    // Keyboard model: tracks which byte must go out next and the outcome the protocol dictates
    task automatic run_cmd(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg,
                           input logic rnd, input logic [15:0] script, input logic use_tbl,
                           input logic [1:0] tbl_err, input int tbl_ntx);
        logic [7:0] seq_b [2];
        logic [7:0] nb;
        logic [1:0] exp_err;
        int nbytes, idx, retry, ntx, code, step, r, k;
        logic fin;
        seq_b[0] = cmd;
        seq_b[1] = arg;
        nbytes   = has_arg ? 2 : 1;
        idx = 0; retry = 0; ntx = 0; step = 0; fin = 1'b0; exp_err = 2'd0;
        accept(cmd, has_arg, arg);
        while (!fin) begin
            wait_tx();
            if (!txValid) break;
            chk("tx_byte", {24'd0, txData}, {24'd0, seq_b[idx]});
            chk("ready_low_tx", {31'd0, cmdReady}, 32'd0);
            handshake(rnd ? int'($urandom_range(0, 3)) : 0);
            ntx++;
            if (rnd) begin
                r    = int'($urandom_range(0, 19));
                code = (r < 14) ? 0 : ((r < 19) ? 1 : 2);
                k    = int'($urandom_range(0, 2));
                for (int i = 0; i < k; i++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    do nb = 8'($urandom); while (nb == 8'hFA || nb == 8'hFE);
                    scan_q.push_back(nb);
                    send_rx(nb);
                end
                repeat ($urandom_range(0, 4)) tick();
            end else begin
                code = int'(script[2*step +: 2]);
            end
            step = (step < 7) ? step + 1 : 7;
            if (code == 0) begin
                send_rx(8'hFA);
                idx++;
                retry = 0;
                if (idx == nbytes) begin
                    fin = 1'b1;
                    exp_err = 2'd0;
                end
            end else if (code == 1) begin
                send_rx(8'hFE);
                if (retry == MR) begin
                    fin = 1'b1;
                    exp_err = 2'd2;
                end else begin
                    retry++;
                end
            end else begin
                fin = 1'b1;
                exp_err = 2'd1;
            end
        end
        finish_done(use_tbl ? tbl_err : exp_err);
        if (use_tbl) chk("tx_count", ntx, tbl_ntx);
    endtask

    // bat_mode: 0 answer AA, 1 noise byte then FC, 2 stay silent
    task automatic run_init(input int bat_mode, input logic [1:0] exp_err);
        int n = 0;
        chk("init_busy", {31'd0, busy}, 32'd1);
        chk("init_ready_low", {31'd0, cmdReady}, 32'd0);
        chk("init_done_pre", {31'd0, initDone}, 32'd0);
        wait_tx();
        chk("init_tx_ff", {24'd0, txData}, 32'h0000_00FF);
        handshake(0);
        repeat (3) tick();
        send_rx(8'hFA);
        if (bat_mode == 0) begin
            repeat (10) tick();
            send_rx(8'hAA);
        end else if (bat_mode == 1) begin
            repeat (2) tick();
            scan_q.push_back(8'h12);
            send_rx(8'h12);
            repeat (4) tick();
            send_rx(8'hFC);
        end else begin
            while (!doneValid && n < 400) begin
                tick();
                n++;
            end
            chk("bat_timeout_cycles", n, 256);
        end
        chk("init_done_valid", {31'd0, doneValid}, 32'd1);
        chk("init_err", {30'd0, doneErr}, {30'd0, exp_err});
        tick();
        chk("init_done_pulse", {31'd0, doneValid}, 32'd0);
        chk("init_done_sticky", {31'd0, initDone}, 32'd1);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, cmdReady}, 32'd1);
    endtask

    initial begin
        int n;
        tbl[0] = '{8'hED, 1'b1, 8'h02, 16'h0000, 2'd0, 2};
        tbl[1] = '{8'hF4, 1'b0, 8'h00, 16'h0055, 2'd2, 4};
        tbl[2] = '{8'hF4, 1'b0, 8'h00, 16'h0002, 2'd1, 1};
        tbl[3] = '{8'hEE, 1'b0, 8'h00, 16'h0001, 2'd0, 2};
        tbl[4] = '{8'hF3, 1'b1, 8'h20, 16'h0014, 2'd0, 4};
        tbl[5] = '{8'hF3, 1'b1, 8'h20, 16'h5515, 2'd2, 8};
        tbl[6] = '{8'hED, 1'b1, 8'h07, 16'h0008, 2'd1, 2};
        tbl[7] = '{8'hF5, 1'b0, 8'h00, 16'h0015, 2'd0, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txValid", {31'd0, txValid}, 32'd0);
        chk("rst_cmdReady", {31'd0, cmdReady}, 32'd0);
        chk("rst_doneValid", {31'd0, doneValid}, 32'd0);
        chk("rst_doneErr", {30'd0, doneErr}, 32'd0);
        chk("rst_scanValid", {31'd0, scanValid}, 32'd0);
        chk("rst_scanData", {24'd0, scanData}, 32'd0);
        chk("rst_initDone", {31'd0, initDone}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b1;
        run_init(0, 2'd0);

        scan_q.push_back(8'h55);
        send_rx(8'h55);
        chk("idle_fwd_valid", {31'd0, scanValid}, 32'd1);
        chk("idle_fwd_data", {24'd0, scanData}, 32'h55);

        for (int i = 0; i < 8; i++)
            run_cmd(tbl[i].cmd, tbl[i].has_arg, tbl[i].arg, 1'b0, tbl[i].script, 1'b1,
                    tbl[i].err, tbl[i].ntx);

        // ACK timeout lands exactly 64 cycles after the tx handshake
        accept(8'hF4, 1'b0, 8'h00);
        wait_tx();
        handshake(0);
        n = 0;
        while (!doneValid && n < 200) begin
            tick();
            n++;
        end
        chk("ack_timeout_cycles", n, 64);
        finish_done(2'd1);

        // rx on the would-be timeout cycle is forwarded and the wait continues
        accept(8'hF4, 1'b0, 8'h00);
        wait_tx();
        handshake(0);
        repeat (63) tick();
        chk("no_early_timeout", {31'd0, doneValid}, 32'd0);
        scan_q.push_back(8'h1C);
        send_rx(8'h1C);
        chk("rx_beats_timeout", {31'd0, doneValid}, 32'd0);
        chk("late_scan_valid", {31'd0, scanValid}, 32'd1);
        chk("late_scan_data", {24'd0, scanData}, 32'h1C);
        send_rx(8'hFA);
        finish_done(2'd0);

        // Scan byte one cycle after rxValid, consumed ACK never forwarded
        accept(8'hEE, 1'b0, 8'h00);
        wait_tx();
        handshake(0);
        tick();
        scan_q.push_back(8'h1C);
        send_rx(8'h1C);
        chk("scan_lat_valid", {31'd0, scanValid}, 32'd1);
        chk("scan_lat_data", {24'd0, scanData}, 32'h1C);
        send_rx(8'hFA);
        chk("ack_not_forwarded", {31'd0, scanValid}, 32'd0);
        finish_done(2'd0);

        // ACK byte during TX is forwarded, not taken as an acknowledge
        accept(8'hF4, 1'b0, 8'h00);
        scan_q.push_back(8'hFA);
        send_rx(8'hFA);
        chk("tx_held_on_rx", {31'd0, txValid}, 32'd1);
        chk("tx_rx_fwd_data", {24'd0, scanData}, 32'hFA);
        handshake(0);
        send_rx(8'hFA);
        finish_done(2'd0);

        for (int i = 0; i < 40; i++)
            run_cmd(8'($urandom), 1'($urandom), 8'($urandom), 1'b1, 16'h0000, 1'b0, 2'd0, 0);

        // Asynchronous reset in ACK, then the init sequence reruns and reports BAT failure
        accept(8'hF3, 1'b1, 8'h20);
        wait_tx();
        handshake(0);
        repeat (2) tick();
        #2 rstn = 1'b0;
        #1;
        chk("arst_txValid", {31'd0, txValid}, 32'd0);
        chk("arst_doneValid", {31'd0, doneValid}, 32'd0);
        chk("arst_cmdReady", {31'd0, cmdReady}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        chk("arst_initDone", {31'd0, initDone}, 32'd0);
        chk("arst_scanData", {24'd0, scanData}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        run_init(1, 2'd3);

        // BAT wait times out exactly 256 cycles after the ACK
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        run_init(2, 2'd1);

        repeat (3) tick();
        chk("scan_queue_empty", scan_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "time limit");
    end

endmodule
